// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder around one full-adder slice.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_n;
    logic             load;
    logic             last;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] sum_sr;
    logic [WIDTH-1:0] sum_nxt;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             fa_s;
    logic             fa_c;

    // The one-bit full-adder slice.
    assign {fa_c, fa_s} = {1'b0, a_sr[0]} + {1'b0, b_sr[0]} + {1'b0, carry};
    assign sum_nxt      = {fa_s, sum_sr};

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        load    = 1'b0;
        last    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_n = RUN;
                end
            end
            RUN: begin
                if (cnt == LAST) begin
                    last    = 1'b1;
                    state_n = DONE;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            sum    <= '0;
            c_out  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf    <= 1'b0;
`endif
        end else if (load) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= c_in;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
            sum_sr <= sum_nxt[WIDTH-1:1];
            carry  <= fa_c;
            cnt    <= cnt + 1'b1;
            // Outputs only move on the final bit, never showing partials.
            if (last) begin
                sum   <= sum_nxt;
                c_out <= fa_c;
`ifdef SERIAL_ADDER_OVF_EN
                ovf   <= carry ^ fa_c;
`endif
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for serial_adder at WIDTH=8.
// Overflow checks are built when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         c_out;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [W:0] exp_q[$];

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .c_out (c_out)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    // Called at a negedge in IDLE; returns at the negedge after the start edge.
    task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                            input logic tc);
        logic [W:0] e;
        e = {1'b0, ta} + {1'b0, tb_} + {{W{1'b0}}, tc};
        exp_q.push_back(e);
        start = 1'b1;
        a     = ta;
        b     = tb_;
        c_in  = tc;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        while (cyc < 20) begin
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        c_in  = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({busy, done, c_out, sum} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got busy=%b done=%b c_out=%b sum=%h want all 0",
                     busy, done, c_out, sum);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle got busy=%b want 0", busy);
        end
    endtask

    task automatic test_basic;
        logic [W:0] e;
        start_op(8'h35, 8'h4A, 1'b0);
        for (int i = 0; i < W; i++) begin
            n_cmp++;
            if (busy !== 1'b1 || done !== 1'b0 || sum !== 8'h00) begin
                n_err++;
                $display("FAIL basic_run%0d got busy=%b done=%b sum=%h want 1 0 00",
                         i, busy, done, sum);
            end
            @(negedge clk);
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL basic_done got done=%b busy=%b want 1 1", done, busy);
        end
        n_cmp++;
        if ({c_out, sum} !== e) begin
            n_err++;
            $display("FAIL basic_result got %h want %h", {c_out, sum}, e);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL basic_after got done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_wrap;
        logic [W:0] e;
        int cyc;
        bit ok;
        for (int i = 0; i < 2; i++) begin
            if (i == 0) start_op(8'hFF, 8'h01, 1'b0);
            else        start_op(8'h00, 8'h00, 1'b1);
            wait_done(cyc, ok);
            e = exp_q.pop_front();
            n_cmp++;
            if (!ok || cyc != W) begin
                n_err++;
                $display("FAIL wrap%0d_latency got ok=%b cyc=%0d want 1 %0d", i, ok, cyc, W);
            end
            n_cmp++;
            if ({c_out, sum} !== e) begin
                n_err++;
                $display("FAIL wrap%0d_result got %h want %h", i, {c_out, sum}, e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_busy_protect;
        logic [W:0] e;
        logic [W:0] got;
        int ndone;
        int tdone;
        ndone = 0;
        tdone = -1;
        got   = '0;
        start_op(8'h10, 8'h20, 1'b0);
        for (int n = 0; n <= 12; n++) begin
            if (done === 1'b1) begin
                ndone++;
                tdone = n;
                got   = {c_out, sum};
            end
            if (n == 2) begin
                start = 1'b1;
                a     = 8'hFF;
                b     = 8'hFF;
            end else if (n == 3) begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (ndone != 1 || tdone != W) begin
            n_err++;
            $display("FAIL busy_done_count got %0d at %0d want 1 at %0d", ndone, tdone, W);
        end
        n_cmp++;
        if (got !== e) begin
            n_err++;
            $display("FAIL busy_result got %h want %h", got, e);
        end
    endtask

    task automatic test_reset_mid;
        logic [W:0] e;
        int cyc;
        bit ok;
        start_op(8'hAA, 8'h55, 1'b0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_pre got busy=%b want 1", busy);
        end
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        n_cmp++;
        if ({busy, done, c_out, sum} !== '0) begin
            n_err++;
            $display("FAIL rstmid_async got busy=%b done=%b c_out=%b sum=%h want all 0",
                     busy, done, c_out, sum);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_op(8'h01, 8'h02, 1'b0);
        wait_done(cyc, ok);
        e = exp_q.pop_front();
        n_cmp++;
        if (!ok || cyc != W || {c_out, sum} !== e) begin
            n_err++;
            $display("FAIL rstmid_after got ok=%b cyc=%0d res=%h want 1 %0d %h",
                     ok, cyc, {c_out, sum}, W, e);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [W:0] e;
        int t[2];
        int nd;
        nd   = 0;
        t[0] = -1;
        t[1] = -1;
        exp_q.push_back({1'b0, 8'hFF} + {1'b0, 8'hFF} + 9'd1);
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'hFF;
        c_in  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        exp_q.push_back({1'b0, 8'h80} + {1'b0, 8'h80});
        a    = 8'h80;
        b    = 8'h80;
        c_in = 1'b0;
        for (int n = 0; n < 30; n++) begin
            if (done === 1'b1) begin
                t[nd] = n;
                e = exp_q.pop_front();
                n_cmp++;
                if ({c_out, sum} !== e) begin
                    n_err++;
                    $display("FAIL b2b_result%0d got %h want %h", nd, {c_out, sum}, e);
                end
                nd++;
                if (nd == 2) begin
                    start = 1'b0;
                    break;
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        n_cmp++;
        if (nd != 2 || (t[1] - t[0]) != W + 2) begin
            n_err++;
            $display("FAIL b2b_spacing got n=%0d gap=%0d want 2 %0d", nd, t[1] - t[0], W + 2);
        end
        @(negedge clk);
    endtask

`ifdef SERIAL_ADDER_OVF_EN
    task automatic test_ovf;
        logic [W:0] e;
        int cyc;
        bit ok;
        for (int i = 0; i < 2; i++) begin
            if (i == 0) start_op(8'h7F, 8'h01, 1'b0);
            else        start_op(8'hFF, 8'h01, 1'b0);
            wait_done(cyc, ok);
            e = exp_q.pop_front();
            n_cmp++;
            if (!ok || {c_out, sum} !== e || ovf !== (i == 0)) begin
                n_err++;
                $display("FAIL ovf%0d got ok=%b res=%h ovf=%b want 1 %h %b",
                         i, ok, {c_out, sum}, ovf, e, (i == 0));
            end
            @(negedge clk);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_busy_protect();
        test_reset_mid();
        test_back_to_back();
`ifdef SERIAL_ADDER_OVF_EN
        test_ovf();
`endif
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain got %0d left want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
